uart_mmio: RTL

Memory-mapped I/O responder for the CPU's UART window. When the address partition flags an access as I/O (address bits [31:28] = 4'b1000), this block decodes the word offset and serves the access. Loads return status, received bytes or counters; stores push transmit bytes or clear counters. It sits between the CPU memory stage and the UART transmitter and receiver. It buffers received bytes in a small FIFO and holds one pending transmit byte.

---
 rtl/uart_mmio.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// UART window responder: decodes word offsets and serves status, TX holding
// register, RX byte FIFO and the cycle/instruction counters.
module uart_mmio #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_UART,
  input  logic [31:0] memAddr,
  input  logic        re,
  input  logic        we,
  input  logic        stall,
  input  logic [31:0] wdata,
  input  logic        instr_commit,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OFF_TXS = 6'h00;
  localparam logic [5:0] OFF_RXS = 6'h01;
  localparam logic [5:0] OFF_TXD = 6'h02;
  localparam logic [5:0] OFF_RXD = 6'h03;
  localparam logic [5:0] OFF_CYC = 6'h04;
  localparam logic [5:0] OFF_INS = 6'h05;

  logic [31:0]   rdata_q, rdata_d, rd_val_s;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_full_q, tx_full_d;
  logic [7:0]    rx_mem_q [RX_DEPTH];
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [31:0]   cyc_q, cyc_d, ins_q, ins_d;

  logic [5:0] off_s;
  logic       acc_rd_s, acc_wr_s, rx_empty_s, rx_full_s, push_s, pop_s, clr_s;
  logic       unused_s;

  assign off_s      = memAddr[7:2];
  assign acc_rd_s   = is_UART & re & ~stall;
  assign acc_wr_s   = is_UART & we & ~stall;
  assign rx_empty_s = (rx_cnt_q == CW'(0));
  assign rx_full_s  = (rx_cnt_q == CW'(RX_DEPTH));
  assign push_s     = rx_valid & ~rx_full_s;
  assign pop_s      = acc_rd_s & (off_s == OFF_RXD) & ~rx_empty_s;
  assign clr_s      = acc_wr_s & (off_s == OFF_CYC);
  assign unused_s   = ^{memAddr[31:8], memAddr[1:0], wdata[31:8]};

  // Load data mux over start-of-cycle register contents
  always_comb begin
    rd_val_s = 32'h0000_0000;
    case (off_s)
      OFF_TXS: rd_val_s = {31'h0, ~tx_full_q};
      OFF_RXS: rd_val_s = {31'h0, ~rx_empty_s};
      OFF_RXD: begin
        if (rx_empty_s) rd_val_s = 32'h0000_0000;
        else            rd_val_s = {24'h0, rx_mem_q[rx_rptr_q]};
      end
      OFF_CYC: rd_val_s = cyc_q;
      OFF_INS: rd_val_s = ins_q;
      default: rd_val_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic for load data, TX holding register, FIFO and counters
  always_comb begin
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    tx_full_d = tx_full_q;
    if (acc_rd_s) rdata_d = rd_val_s;
    else          rdata_d = rdata_q;
    // acceptance uses start-of-cycle tx_full, so a write during a handshake is lost
    if (tx_full_q) begin
      if (tx_ready) tx_full_d = 1'b0;
      else          tx_full_d = 1'b1;
    end else if (acc_wr_s && (off_s == OFF_TXD)) begin
      tx_full_d = 1'b1;
      tx_data_d = wdata[7:0];
    end else begin
      tx_full_d = 1'b0;
    end
    if (push_s) rx_wptr_d = rx_wptr_q + PW'(1);
    else        rx_wptr_d = rx_wptr_q;
    if (pop_s) rx_rptr_d = rx_rptr_q + PW'(1);
    else       rx_rptr_d = rx_rptr_q;
    case ({push_s, pop_s})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (clr_s) begin
      cyc_d = 32'h0000_0000;
      ins_d = 32'h0000_0000;
    end else begin
      cyc_d = cyc_q + 32'd1;
      ins_d = ins_q + {31'h0, instr_commit};
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= 32'h0000_0000;
      tx_data_q <= 8'h00;
      tx_full_q <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      cyc_q     <= 32'h0000_0000;
      ins_q     <= 32'h0000_0000;
    end else begin
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      tx_full_q <= tx_full_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push_s) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  assign rdata    = rdata_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_full_q;
  assign rx_ready = ~rx_full_s;

endmodule
